// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants, instruction field ranges and write-back control types
// shared by the write-back stage and its decoder.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam int OP_HI = 31;
  localparam int OP_LO = 26;
  localparam int RS_HI = 25;
  localparam int RS_LO = 21;
  localparam int RT_HI = 20;
  localparam int RT_LO = 16;
  localparam int RD_HI = 15;
  localparam int RD_LO = 11;
  localparam int FN_HI = 5;
  localparam int FN_LO = 0;

  localparam logic [1:0] MEM2REG_ALU  = 2'b00;
  localparam logic [1:0] MEM2REG_DM   = 2'b01;
  localparam logic [1:0] MEM2REG_LINK = 2'b10;

  typedef enum logic [1:0] {
    DEST_NONE = 2'b00,
    DEST_RD   = 2'b01,
    DEST_RT   = 2'b10,
    DEST_LINK = 2'b11
  } dest_sel_e;

  typedef struct packed {
    logic       write;
    dest_sel_e  dest;
    logic [1:0] mem2reg;
  } wb_ctrl_t;

endpackage

// File: rtl/wb_decode.sv
// Combinational W-stage decoder: opcode/funct to register-write control.
module wb_decode
  import mips_isa_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output wb_ctrl_t   ctrl
);

  always_comb begin
    ctrl.write   = 1'b0;
    ctrl.dest    = DEST_NONE;
    ctrl.mem2reg = MEM2REG_ALU;
    unique case (op)
      OP_RTYPE: begin
        // jr and every other funct fall through as non-writing
        if (funct == FN_ADDU || funct == FN_SUBU || funct == FN_SLT) begin
          ctrl.write = 1'b1;
          ctrl.dest  = DEST_RD;
        end
      end
      OP_ORI, OP_ADDIU, OP_LUI: begin
        ctrl.write = 1'b1;
        ctrl.dest  = DEST_RT;
      end
      OP_LW: begin
        ctrl.write   = 1'b1;
        ctrl.dest    = DEST_RT;
        ctrl.mem2reg = MEM2REG_DM;
      end
      OP_JAL: begin
        ctrl.write   = 1'b1;
        ctrl.dest    = DEST_LINK;
        ctrl.mem2reg = MEM2REG_LINK;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_stage_ctrl.sv
// MIPS write-back stage: M->W register with stall/flush, decode, GRF write port.
// Optional retired-instruction counter enabled by macro WB_RETIRE_CNT_EN.
module wb_stage_ctrl
  import mips_isa_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int RA_W     = 5,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_W,
  input  logic              flush_W,
  input  logic              valid_M,
  input  logic [31:0]       instr_M,
  input  logic [DATA_W-1:0] pc8_M,
  input  logic [DATA_W-1:0] alu_M,
  input  logic [DATA_W-1:0] dm_M,
  output logic              valid_W,
  output logic [31:0]       instr_W,
  output logic [1:0]        mem2reg_W,
  output logic              reg_we,
  output logic [RA_W-1:0]   reg_waddr,
  output logic [DATA_W-1:0] reg_wdata
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  logic              vld_p0;
  logic [31:0]       instr_p0;
  logic [DATA_W-1:0] pc8_p0;
  logic [DATA_W-1:0] alu_p0;
  logic [DATA_W-1:0] dm_p0;
  wb_ctrl_t          ctrl_p0;
  logic [RA_W-1:0]   waddr_p0;

  function automatic logic [DATA_W-1:0] sel_wdata(
    input logic [1:0]        sel,
    input logic [DATA_W-1:0] alu,
    input logic [DATA_W-1:0] dm,
    input logic [DATA_W-1:0] pc8
  );
    case (sel)
      MEM2REG_ALU:  sel_wdata = alu;
      MEM2REG_DM:   sel_wdata = dm;
      MEM2REG_LINK: sel_wdata = pc8;
      default:      sel_wdata = '0;
    endcase
  endfunction

  // M -> W stage boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      instr_p0 <= '0;
      pc8_p0   <= '0;
      alu_p0   <= '0;
      dm_p0    <= '0;
    end else if (flush_W) begin
      vld_p0   <= 1'b0;
      instr_p0 <= '0;
      pc8_p0   <= '0;
      alu_p0   <= '0;
      dm_p0    <= '0;
    end else if (!stall_W) begin
      vld_p0   <= valid_M;
      instr_p0 <= instr_M;
      pc8_p0   <= pc8_M;
      alu_p0   <= alu_M;
      dm_p0    <= dm_M;
    end
  end

  wb_decode u_decode (
    .op    (instr_p0[OP_HI:OP_LO]),
    .funct (instr_p0[FN_HI:FN_LO]),
    .ctrl  (ctrl_p0)
  );

  always_comb begin
    waddr_p0 = '0;
    case (ctrl_p0.dest)
      DEST_RD:   waddr_p0 = RA_W'(instr_p0[RD_HI:RD_LO]);
      DEST_RT:   waddr_p0 = RA_W'(instr_p0[RT_HI:RT_LO]);
      DEST_LINK: waddr_p0 = RA_W'(LINK_REG);
      default:   waddr_p0 = '0;
    endcase
  end

  assign valid_W   = vld_p0;
  assign instr_W   = instr_p0;
  assign mem2reg_W = ctrl_p0.mem2reg;
  assign reg_waddr = waddr_p0;
  // $0 is hard-wired zero, so a write aimed at it is dropped here
  assign reg_we    = vld_p0 & ctrl_p0.write & (waddr_p0 != '0);
  assign reg_wdata = sel_wdata(ctrl_p0.mem2reg, alu_p0, dm_p0, pc8_p0);

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt_q;

  // an instruction retires on the edge where it leaves W; flush does not undo that
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt_q <= '0;
    end else if (vld_p0 && !stall_W) begin
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage_ctrl.sv
// Scoreboard bench for wb_stage_ctrl: driver pushes expected W outputs, monitor pops and compares.
module tb_wb_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_W = 1'b0, flush_W = 1'b0, valid_M = 1'b0;
  logic [31:0] instr_M = '0, pc8_M = '0, alu_M = '0, dm_M = '0;
  logic        valid_W, reg_we;
  logic [31:0] instr_W, reg_wdata;
  logic [1:0]  mem2reg_W;
  logic [4:0]  reg_waddr;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  wb_stage_ctrl #(.DATA_W(32), .RA_W(5), .LINK_REG(31)) dut (
    .clk(clk), .rst_n(rst_n), .stall_W(stall_W), .flush_W(flush_W),
    .valid_M(valid_M), .instr_M(instr_M), .pc8_M(pc8_M), .alu_M(alu_M), .dm_M(dm_M),
    .valid_W(valid_W), .instr_W(instr_W), .mem2reg_W(mem2reg_W), .reg_we(reg_we),
    .reg_waddr(reg_waddr), .reg_wdata(reg_wdata)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] instr;
    logic [1:0]  m2r;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [31:0] rc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  // reference state of the W slot
  logic        m_v;
  logic [31:0] m_instr, m_pc8, m_alu, m_dm, m_rc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h @%0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    logic [5:0] op, fn;
    logic wr;
    logic [4:0] dest;
    logic [1:0] sel;
    op = m_instr[31:26];
    fn = m_instr[5:0];
    wr = 1'b0; dest = 5'd0; sel = 2'b00;
    if (op == 6'h00 && (fn == 6'h21 || fn == 6'h23 || fn == 6'h2a)) begin
      wr = 1'b1; dest = m_instr[15:11];
    end else if (op == 6'h0d || op == 6'h09 || op == 6'h0f) begin
      wr = 1'b1; dest = m_instr[20:16];
    end else if (op == 6'h23) begin
      wr = 1'b1; dest = m_instr[20:16]; sel = 2'b01;
    end else if (op == 6'h03) begin
      wr = 1'b1; dest = 5'd31; sel = 2'b10;
    end
    e.v     = m_v;
    e.instr = m_instr;
    e.m2r   = sel;
    e.wa    = wr ? dest : 5'd0;
    e.we    = m_v && wr && (dest != 5'd0);
    e.wd    = (sel == 2'b00) ? m_alu : (sel == 2'b01) ? m_dm : m_pc8;
    e.rc    = m_rc;
    return e;
  endfunction

  task automatic model_clear(input logic clr_cnt);
    m_v = 1'b0; m_instr = '0; m_pc8 = '0; m_alu = '0; m_dm = '0;
    if (clr_cnt) m_rc = '0;
  endtask

  task automatic step(input logic fl, input logic st, input logic vm,
                      input logic [31:0] im, input logic [31:0] pc,
                      input logic [31:0] al, input logic [31:0] dmv);
    @(negedge clk);
    flush_W = fl; stall_W = st; valid_M = vm;
    instr_M = im; pc8_M = pc; alu_M = al; dm_M = dmv;
    if (m_v && !st) m_rc = m_rc + 32'd1;
    if (fl) model_clear(1'b0);
    else if (!st) begin
      m_v = vm; m_instr = im; m_pc8 = pc; m_alu = al; m_dm = dmv;
    end
    q.push_back(model_out());
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs, rt, rd;
    logic [15:0] imm;
    rs  = 5'($urandom);
    rt  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    rd  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
    imm = 16'($urandom);
    case ($urandom_range(0, 12))
      0:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      1:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      2:  return {6'h00, rs, rt, rd, 5'd0, 6'h2a};
      3:  return {6'h0d, rs, rt, imm};
      4:  return {6'h09, rs, rt, imm};
      5:  return {6'h0f, 5'd0, rt, imm};
      6:  return {6'h23, rs, rt, imm};
      7:  return {6'h2b, rs, rt, imm};
      8:  return {6'h04, rs, rt, imm};
      9:  return {6'h02, 26'($urandom)};
      10: return {6'h03, 26'($urandom)};
      11: return {6'h00, rs, 15'd0, 6'h08};
      default: return $urandom;
    endcase
  endfunction

  // monitor: compare DUT outputs against the oldest expected entry
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("valid_W",   32'(valid_W),   32'(e.v));
      chk("instr_W",   instr_W,        e.instr);
      chk("mem2reg_W", 32'(mem2reg_W), 32'(e.m2r));
      chk("reg_we",    32'(reg_we),    32'(e.we));
      chk("reg_waddr", 32'(reg_waddr), 32'(e.wa));
      chk("reg_wdata", reg_wdata,      e.wd);
`ifdef WB_RETIRE_CNT_EN
      chk("retire_cnt", retire_cnt,    e.rc);
`endif
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flush_W = 1'b0; stall_W = 1'b0; valid_M = 1'b0;
    model_clear(1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_clear(1'b1);
    repeat (2) @(negedge clk);
    chk("rst_valid_W",   32'(valid_W),   32'd0);
    chk("rst_instr_W",   instr_W,        32'd0);
    chk("rst_reg_we",    32'(reg_we),    32'd0);
    chk("rst_reg_waddr", 32'(reg_waddr), 32'd0);
    chk("rst_reg_wdata", reg_wdata,      32'd0);
    chk("rst_mem2reg",   32'(mem2reg_W), 32'd0);
`ifdef WB_RETIRE_CNT_EN
    chk("rst_retire_cnt", retire_cnt,    32'd0);
`endif
    rst_n = 1'b1;

    // directed: addu, lw, jal, ori to $0, sw, beq, jr
    step(0, 0, 1, 32'h00432021, 32'h0000_1008, 32'h12345678, 32'h0);
    step(0, 0, 1, 32'h8C250000, 32'h0000_100C, 32'h0000_0040, 32'hDEADBEEF);
    step(0, 0, 1, 32'h0C000C02, 32'h0000_3008, 32'h5555_AAAA, 32'h0BAD_F00D);
    step(0, 0, 1, 32'h342000FF, 32'h0000_3010, 32'h0000_00FF, 32'h0);
    step(0, 0, 1, 32'hAC250000, 32'h0000_3014, 32'h0000_0100, 32'h1111_2222);
    step(0, 0, 1, 32'h10220003, 32'h0000_3018, 32'h0000_0001, 32'h3333_4444);
    step(0, 0, 1, 32'h03E00008, 32'h0000_301C, 32'h0000_0002, 32'h5555_6666);

    // lw held for three stall cycles, then flush together with stall
    step(0, 0, 1, 32'h8C250000, 32'h0000_2008, 32'h0000_0080, 32'hCAFEBABE);
    for (int i = 0; i < 3; i++)
      step(0, 1, 1, rand_instr(), $urandom, $urandom, $urandom);
    step(1, 1, 1, 32'h00432021, 32'h1, 32'h2, 32'h3);
    step(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);

    // five retirements with one bubble and two stall cycles
    do_reset();
    step(0, 0, 1, 32'h00432021, 32'h8, 32'h1, 32'h0);
    step(0, 0, 1, 32'h8C250000, 32'hC, 32'h2, 32'h7);
    step(0, 0, 0, 32'h00432021, 32'h10, 32'h3, 32'h0);
    step(0, 0, 1, 32'h0C000C02, 32'h14, 32'h4, 32'h0);
    step(0, 1, 1, 32'h342000FF, 32'h18, 32'h5, 32'h0);
    step(0, 1, 1, 32'h342000FF, 32'h18, 32'h5, 32'h0);
    step(0, 0, 1, 32'h3C0A1234, 32'h1C, 32'h6, 32'h0);
    step(0, 0, 1, 32'h2529FFFF, 32'h20, 32'h7, 32'h0);
    step(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
`ifdef WB_RETIRE_CNT_EN
    @(posedge clk); #2;
    chk("retire_cnt_five", retire_cnt, 32'd5);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 7) != 0), rand_instr(), $urandom, $urandom, $urandom);

    // async reset mid-stall with a jal held in W
    step(0, 0, 1, 32'h0C000C02, 32'h0000_3008, 32'h0, 32'h0);
    step(0, 1, 1, 32'h00432021, 32'h0, 32'h0, 32'h0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid_W", 32'(valid_W), 32'd0);
    chk("async_rst_reg_we",  32'(reg_we),  32'd0);
    chk("async_rst_wdata",   reg_wdata,    32'd0);
    chk("async_rst_waddr",   32'(reg_waddr), 32'd0);
    model_clear(1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 1, 32'h8C250000, 32'h0, 32'h0, 32'hDEADBEEF);
    step(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
